// File: rtl/galetron_pkg.sv
// Shared definitions for the fetch front end: PC width, opcode classes, sequencer states.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
package galetron_pkg;

  // Architectural program counter width
  localparam int PC_W = 12;

  // Opcode width and the opcodes the fetch sequencer cares about
  localparam int OP_W = 6;
  localparam logic [OP_W-1:0] OP_JUMP_LO = 6'b010010;
  localparam logic [OP_W-1:0] OP_JUMP_HI = 6'b010110;
  localparam logic [OP_W-1:0] OP_JAL     = 6'b010111;
  localparam logic [OP_W-1:0] OP_HALT    = 6'b111111;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    HALT  = 2'd3
  } pc_state_t;

  // True when the opcode belongs to the control-transfer class. JAL sits just
  // above the plain jump range, so it is matched explicitly rather than by
  // widening the range.
  function automatic logic is_transfer_op(input logic [OP_W-1:0] op);
    return ((op >= OP_JUMP_LO) && (op <= OP_JUMP_HI)) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/pc_next_select.sv
// Next fetch address select: taken control transfer -> target, otherwise PC+1 modulo 2^PC_W.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether next_pc is committed.
module pc_next_select
  import galetron_pkg::*;
(
  input  logic [OP_W-1:0] operation,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] jump_address,
  input  logic [PC_W-1:0] program_counter,
  output logic            transfer,
  output logic [PC_W-1:0] next_pc,
  output logic            seq_wrap
);

  logic [PC_W-1:0] pc_inc;

  // Sequential successor; the carry out of the top bit is intentionally dropped
  assign pc_inc = program_counter + PC_W'(1);

  // Transfer decode and next-address mux. seq_wrap flags only the sequential
  // path leaving the all-ones address, so a jump to address zero never counts.
  always_comb begin
    transfer = is_transfer_op(operation) && branch_taken;
    next_pc  = pc_inc;
    seq_wrap = 1'b0;
    if (transfer) begin
      next_pc = jump_address;
    end else begin
      seq_wrap = (program_counter == {PC_W{1'b1}});
    end
  end

endmodule

// File: rtl/program_counter_unit.sv
// Architectural PC register plus BOOT/RUN/STALL/HALT fetch sequencer with jump/branch redirect.
// Latency: a redirect or increment presented in RUN appears on program_counter one clock later.
// Backpressure: stall holds the PC (RUN->STALL); HALT holds it until restart reloads the reset vector.
module program_counter_unit
  import galetron_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VECTOR = 12'h000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [OP_W-1:0] operation,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] jump_address,
  input  logic            stall,
  input  logic            restart,
  output logic [PC_W-1:0] program_counter,
  output logic            pc_valid,
  output logic            halted,
  output logic            pc_wrapped
);

  pc_state_t       state_q;
  pc_state_t       state_d;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic            wrapped_q;
  logic            wrapped_d;

  logic            transfer;
  logic [PC_W-1:0] next_pc;
  logic            seq_wrap;

  pc_next_select u_next (
    .operation       (operation),
    .branch_taken    (branch_taken),
    .jump_address    (jump_address),
    .program_counter (pc_q),
    .transfer        (transfer),
    .next_pc         (next_pc),
    .seq_wrap        (seq_wrap)
  );

  // State, PC and sticky wrap flag; reset drops everything back to BOOT at once
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= BOOT;
      pc_q      <= RESET_VECTOR;
      wrapped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      wrapped_q <= wrapped_d;
    end
  end

  // Sequencer: in RUN, halt beats stall beats redirect beats increment
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    wrapped_d = wrapped_q;
    unique case (state_q)
      BOOT: begin
        // One settle cycle for instruction memory before the first fetch counts
        state_d = RUN;
      end
      RUN: begin
        if (operation == OP_HALT) begin
          state_d = HALT;
        end else if (stall) begin
          state_d = STALL;
        end else begin
          pc_d = next_pc;
          if (seq_wrap) begin
            wrapped_d = 1'b1;
          end
        end
      end
      STALL: begin
        // Opcode and branch inputs are stale while stalled; only stall matters
        if (!stall) begin
          state_d = RUN;
        end
      end
      HALT: begin
        if (restart) begin
          state_d   = BOOT;
          pc_d      = RESET_VECTOR;
          wrapped_d = 1'b0;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // Outputs depend only on registered state, never directly on inputs
  assign program_counter = pc_q;
  assign pc_valid        = (state_q == RUN) || (state_q == STALL);
  assign halted          = (state_q == HALT);
  assign pc_wrapped      = wrapped_q;

endmodule

// File: tb/tb_program_counter_unit.sv
// Scoreboard bench for program_counter_unit: reference model pushes expected outputs per cycle.
// Latency: expectations are popped one clock after the stimulus that produced them.
// Backpressure: stall and halt/restart sequences are driven explicitly.
module tb_program_counter_unit;

  logic        clock;
  logic        reset;
  logic [5:0]  operation;
  logic        branch_taken;
  logic [11:0] jump_address;
  logic        stall;
  logic        restart;
  logic [11:0] program_counter;
  logic        pc_valid;
  logic        halted;
  logic        pc_wrapped;

  int checks;
  int failures;

  // Reference model state (0 BOOT, 1 RUN, 2 STALL, 3 HALT)
  int          m_state;
  logic [11:0] m_pc;
  logic        m_wrap;

  // Expected {pc, valid, halted, wrapped} for the next clock edge
  logic [14:0] exp_q[$];

  program_counter_unit dut (
    .clock           (clock),
    .reset           (reset),
    .operation       (operation),
    .branch_taken    (branch_taken),
    .jump_address    (jump_address),
    .stall           (stall),
    .restart         (restart),
    .program_counter (program_counter),
    .pc_valid        (pc_valid),
    .halted          (halted),
    .pc_wrapped      (pc_wrapped)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point for the whole bench
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs, advance the model, push its prediction, then
  // after the clock edge pop and compare against the DUT.
  task automatic cycle(input logic [5:0] op, input logic bt, input logic [11:0] ja,
                       input logic st, input logic rs, input string tag);
    logic        xfer;
    logic [14:0] e;
    operation    = op;
    branch_taken = bt;
    jump_address = ja;
    stall        = st;
    restart      = rs;
    case (m_state)
      0: m_state = 1;
      1: begin
        if (op == 6'b111111) m_state = 3;
        else if (st) m_state = 2;
        else begin
          xfer = (((op >= 6'b010010) && (op <= 6'b010110)) || (op == 6'b010111)) && bt;
          if (xfer) m_pc = ja;
          else begin
            if (m_pc == 12'hFFF) m_wrap = 1'b1;
            m_pc = m_pc + 12'd1;
          end
        end
      end
      2: if (!st) m_state = 1;
      default: if (rs) begin m_state = 0; m_pc = 12'h000; m_wrap = 1'b0; end
    endcase
    exp_q.push_back({m_pc, (m_state == 1 || m_state == 2), (m_state == 3), m_wrap});
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      check_eq({tag, "_queue_empty"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_pc"},      32'(program_counter), 32'(e[14:3]));
      check_eq({tag, "_valid"},   32'(pc_valid),        32'(e[2]));
      check_eq({tag, "_halted"},  32'(halted),          32'(e[1]));
      check_eq({tag, "_wrapped"}, 32'(pc_wrapped),      32'(e[0]));
    end
    @(negedge clock);
  endtask

  task automatic run_n(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(6'd0, 1'b0, 12'h000, 1'b0, 1'b0, tag);
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    reset        = 1'b0;
    operation    = 6'd0;
    branch_taken = 1'b0;
    jump_address = 12'h000;
    stall        = 1'b0;
    restart      = 1'b0;
    m_state      = 0;
    m_pc         = 12'h000;
    m_wrap       = 1'b0;

    // Reset state before any clock edge
    #3;
    check_eq("rst_pc",      32'(program_counter), 32'h000);
    check_eq("rst_valid",   32'(pc_valid),        32'd0);
    check_eq("rst_halted",  32'(halted),          32'd0);
    check_eq("rst_wrapped", 32'(pc_wrapped),      32'd0);
    @(negedge clock);
    reset = 1'b1;

    // 1: BOOT then sequential fetch 000,001,...
    check_eq("boot_valid", 32'(pc_valid), 32'd0);
    run_n(6, "seq");
    check_eq("seq_pc5", 32'(program_counter), 32'h005);

    // 2: taken and not-taken control transfer at PC=005
    cycle(6'b010011, 1'b1, 12'h0A0, 1'b0, 1'b0, "jmp_taken");
    check_eq("jmp_taken_abs", 32'(program_counter), 32'h0A0);
    cycle(6'b010010, 1'b1, 12'h005, 1'b0, 1'b0, "jmp_lo");
    cycle(6'b010011, 1'b0, 12'h0A0, 1'b0, 1'b0, "jmp_nt");
    check_eq("jmp_nt_abs", 32'(program_counter), 32'h006);
    // Range edges: JUMP_HI and JAL transfer, neighbours outside the class do not
    cycle(6'b010110, 1'b1, 12'h100, 1'b0, 1'b0, "jmp_hi");
    cycle(6'b010001, 1'b1, 12'h300, 1'b0, 1'b0, "below_lo");
    cycle(6'b011000, 1'b1, 12'h300, 1'b0, 1'b0, "above_jal");
    check_eq("nonxfer_abs", 32'(program_counter), 32'h102);

    // 3: stall at PC=010; opcode inputs ignored while in STALL
    cycle(6'b010111, 1'b1, 12'h010, 1'b0, 1'b0, "jal");
    cycle(6'd0,      1'b0, 12'h000, 1'b1, 1'b0, "stall1");
    cycle(6'b111111, 1'b1, 12'h3FF, 1'b1, 1'b0, "stall2");
    cycle(6'b010011, 1'b1, 12'h3FF, 1'b1, 1'b0, "stall3");
    cycle(6'd0,      1'b0, 12'h000, 1'b0, 1'b0, "unstall");
    check_eq("stall_hold", 32'(program_counter), 32'h010);
    run_n(1, "post_stall");
    check_eq("post_stall_abs", 32'(program_counter), 32'h011);

    // 4: wrap from FFF to 000 is sticky; restart outside HALT is ignored
    cycle(6'b010100, 1'b1, 12'hFFE, 1'b0, 1'b0, "to_ffe");
    run_n(2, "wrap");
    check_eq("wrap_flag", 32'(pc_wrapped), 32'd1);
    cycle(6'd0, 1'b0, 12'h000, 1'b0, 1'b1, "restart_ignored");
    check_eq("wrap_sticky", 32'(pc_wrapped), 32'd1);

    // 5: halt honoured under stall, then restart
    cycle(6'b010010, 1'b1, 12'h020, 1'b0, 1'b0, "to_020");
    cycle(6'b111111, 1'b0, 12'h000, 1'b1, 1'b0, "halt");
    check_eq("halt_flag", 32'(halted), 32'd1);
    check_eq("halt_pc",   32'(program_counter), 32'h020);
    cycle(6'd0, 1'b0, 12'h000, 1'b0, 1'b0, "halt_hold");
    cycle(6'd0, 1'b0, 12'h000, 1'b0, 1'b1, "restart");
    check_eq("restart_wrap", 32'(pc_wrapped), 32'd0);
    run_n(3, "after_restart");
    // Jump to 000 must not set the wrap flag
    cycle(6'b010101, 1'b1, 12'h000, 1'b0, 1'b0, "jump_zero");
    check_eq("jump_zero_wrap", 32'(pc_wrapped), 32'd0);

    // 6: asynchronous reset between edges while in STALL
    cycle(6'd0, 1'b0, 12'h000, 1'b1, 1'b0, "pre_arst");
    #2;
    reset = 1'b0;
    #1;
    check_eq("arst_pc",     32'(program_counter), 32'h000);
    check_eq("arst_valid",  32'(pc_valid),        32'd0);
    check_eq("arst_halted", 32'(halted),          32'd0);
    m_state = 0;
    m_pc    = 12'h000;
    m_wrap  = 1'b0;
    stall   = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    run_n(4, "reboot");
    check_eq("reboot_pc", 32'(program_counter), 32'h003);

    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
